ram_2p: RTL and testbench

RAM_2P -- requirements
Module: ram_2p

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_rd_pipe.sv | 49 ++++
 rtl/ram_2p.sv | 180 ++++++++++++++++++
 tb/tb_ram_2p.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: controller states and read-latency limits.
package ram_pkg;

    localparam int unsigned RD_LAT_MAX = 4;

    // INIT clears the array word by word; READY accepts port accesses.
    typedef enum logic {
        StInit  = 1'b0,
        StReady = 1'b1
    } state_e;

    // Keep the read latency inside the supported 1..RD_LAT_MAX window.
    function automatic int unsigned clamp_lat(input int unsigned lat);
        if (lat < 1) begin
            return 1;
        end else if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: carries data/valid/err for a fixed number of cycles.
// Data stages only load behind a valid entry, so the output holds its last read value.
module ram_rd_pipe #(
    parameter int unsigned WORD_WIDTH = 24,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [WORD_WIDTH-1:0] out_data
);

    logic [RD_LAT-1:0]     valid_q;
    logic [RD_LAT-1:0]     err_q;
    logic [WORD_WIDTH-1:0] data_q [RD_LAT];

    // Shift the pipeline every cycle; flush clears every stage synchronously.
    always_ff @(posedge clk) begin
        if (flush) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/ram_2p.sv
// Dual-port RAM with byte enables, power-on clear and configurable read latency.
// Optional macro RAM_BYPASS_EN: a read colliding with the other port's write returns
// the merged post-write word instead of the old contents.
module ram_2p
    import ram_pkg::*;
#(
    parameter int unsigned LINES         = 19200,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned WORD_WIDTH    = 24,
    parameter int unsigned RD_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs_a,
    input  logic                      rnw_a,
    input  logic [ADDRESS_WIDTH-1:0]  add_a,
    input  logic [WORD_WIDTH-1:0]     wr_data_a,
    input  logic [WORD_WIDTH/8-1:0]   wr_be_a,
    output logic [WORD_WIDTH-1:0]     rd_data_a,
    output logic                      rd_valid_a,
    output logic                      err_a,
    input  logic                      cs_b,
    input  logic                      rnw_b,
    input  logic [ADDRESS_WIDTH-1:0]  add_b,
    input  logic [WORD_WIDTH-1:0]     wr_data_b,
    input  logic [WORD_WIDTH/8-1:0]   wr_be_b,
    output logic [WORD_WIDTH-1:0]     rd_data_b,
    output logic                      rd_valid_b,
    output logic                      err_b,
    output logic                      init_done
);

    localparam int unsigned Lat   = clamp_lat(RD_LAT);
    localparam int unsigned Bytes = WORD_WIDTH / 8;
    localparam int unsigned IdxW  = (LINES > 1) ? $clog2(LINES) : 1;
    // One extra count value marks "all words cleared" before moving to READY.
    localparam int unsigned CntW  = $clog2(LINES + 1);

    localparam logic [ADDRESS_WIDTH:0] LinesA = (ADDRESS_WIDTH + 1)'(LINES);
    localparam logic [CntW-1:0]        LinesC = CntW'(LINES);

    logic [WORD_WIDTH-1:0] mem [LINES];

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            init_done_q;
    logic            ready;

    logic            in_range_a, in_range_b;
    logic [IdxW-1:0] idx_a, idx_b;
    logic            wr_a_ok, wr_b_ok, rd_a_ok, rd_b_ok;
    logic [WORD_WIDTH-1:0] word_a, word_b;

    logic                  cap_valid_a, cap_valid_b;
    logic                  cap_err_a, cap_err_b;
    logic [WORD_WIDTH-1:0] cap_data_a, cap_data_b;

    assign ready      = (state_q == StReady);
    assign in_range_a = ({1'b0, add_a} < LinesA);
    assign in_range_b = ({1'b0, add_b} < LinesA);
    assign idx_a      = add_a[IdxW-1:0];
    assign idx_b      = add_b[IdxW-1:0];
    assign wr_a_ok    = ready && cs_a && !rnw_a && in_range_a;
    assign wr_b_ok    = ready && cs_b && !rnw_b && in_range_b;
    assign rd_a_ok    = ready && cs_a && rnw_a && in_range_a;
    assign rd_b_ok    = ready && cs_b && rnw_b && in_range_b;
    assign init_done  = init_done_q;

    // Controller: clear every word in INIT, then stay in READY until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    if (cnt_q == LinesC) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StReady: begin
                    state_q <= StReady;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Array writes: clear during INIT, byte-enabled port writes in READY (port A applied last).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == StInit) begin
                if (cnt_q != LinesC) begin
                    mem[cnt_q[IdxW-1:0]] <= '0;
                end
            end else begin
                for (int unsigned b = 0; b < Bytes; b++) begin
                    if (wr_b_ok && wr_be_b[b]) begin
                        mem[idx_b][8*b +: 8] <= wr_data_b[8*b +: 8];
                    end
                end
                for (int unsigned b = 0; b < Bytes; b++) begin
                    if (wr_a_ok && wr_be_a[b]) begin
                        mem[idx_a][8*b +: 8] <= wr_data_a[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read words seen by each port; a reading port cannot write, so only the other port merges.
    always_comb begin
        word_a = mem[idx_a];
        word_b = mem[idx_b];
`ifdef RAM_BYPASS_EN
        for (int unsigned b = 0; b < Bytes; b++) begin
            if (wr_b_ok && (add_b == add_a) && wr_be_b[b]) begin
                word_a[8*b +: 8] = wr_data_b[8*b +: 8];
            end
            if (wr_a_ok && (add_a == add_b) && wr_be_a[b]) begin
                word_b[8*b +: 8] = wr_data_a[8*b +: 8];
            end
        end
`endif
    end

    // Capture stage: sample the array at the request edge; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_valid_a <= 1'b0;
            cap_err_a   <= 1'b0;
            cap_data_a  <= '0;
            cap_valid_b <= 1'b0;
            cap_err_b   <= 1'b0;
            cap_data_b  <= '0;
        end else begin
            cap_valid_a <= ready && cs_a && rnw_a;
            cap_err_a   <= ready && cs_a && !in_range_a;
            cap_data_a  <= rd_a_ok ? word_a : '0;
            cap_valid_b <= ready && cs_b && rnw_b;
            cap_err_b   <= ready && cs_b && !in_range_b;
            cap_data_b  <= rd_b_ok ? word_b : '0;
        end
    end

    ram_rd_pipe #(
        .WORD_WIDTH (WORD_WIDTH),
        .RD_LAT     (Lat)
    ) u_pipe_a (
        .clk        (clk),
        .flush      (!rst_n),
        .in_valid   (cap_valid_a),
        .in_err     (cap_err_a),
        .in_data    (cap_data_a),
        .out_valid  (rd_valid_a),
        .out_err    (err_a),
        .out_data   (rd_data_a)
    );

    ram_rd_pipe #(
        .WORD_WIDTH (WORD_WIDTH),
        .RD_LAT     (Lat)
    ) u_pipe_b (
        .clk        (clk),
        .flush      (!rst_n),
        .in_valid   (cap_valid_b),
        .in_err     (cap_err_b),
        .in_data    (cap_data_b),
        .out_valid  (rd_valid_b),
        .out_err    (err_b),
        .out_data   (rd_data_b)
    );

endmodule

// File: tb/tb_ram_2p.sv
// Directed bench for ram_2p at default parameters (LINES=19200, RD_LAT=2).
module tb_ram_2p;

    localparam int unsigned LINES = 19200;

`ifdef RAM_BYPASS_EN
    localparam logic [23:0] ExpCollide = 24'h654321;
`else
    localparam logic [23:0] ExpCollide = 24'h123456;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_a, rnw_a, cs_b, rnw_b;
    logic [15:0] add_a, add_b;
    logic [23:0] wr_data_a, wr_data_b;
    logic [2:0]  wr_be_a, wr_be_b;
    logic [23:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, err_a, err_b, init_done;

    int checks = 0;
    int errors = 0;
    int n;
    int spurious;

    always #5 clk = ~clk;

    ram_2p u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_a       (cs_a),
        .rnw_a      (rnw_a),
        .add_a      (add_a),
        .wr_data_a  (wr_data_a),
        .wr_be_a    (wr_be_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .err_a      (err_a),
        .cs_b       (cs_b),
        .rnw_b      (rnw_b),
        .add_b      (add_b),
        .wr_data_b  (wr_data_b),
        .wr_be_b    (wr_be_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .err_b      (err_b),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {rd_valid_a, err_a, rd_valid_b, err_b}.
    task automatic flags(input string tag, input logic [3:0] exp);
        chk(tag, 32'({rd_valid_a, err_a, rd_valid_b, err_b}), 32'(exp));
    endtask

    task automatic set_a(input logic cs, input logic rnw, input int unsigned add,
                         input logic [23:0] d, input logic [2:0] be);
        cs_a = cs; rnw_a = rnw; add_a = 16'(add); wr_data_a = d; wr_be_a = be;
    endtask

    task automatic set_b(input logic cs, input logic rnw, input int unsigned add,
                         input logic [23:0] d, input logic [2:0] be);
        cs_b = cs; rnw_b = rnw; add_b = 16'(add); wr_data_b = d; wr_be_b = be;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b1, 0, 24'h0, 3'b000);
        set_b(1'b0, 1'b1, 0, 24'h0, 3'b000);
    endtask

    // Apply the currently driven request for one edge.
    task automatic issue();
        @(negedge clk);
        idle();
    endtask

    // Apply the driven request at edge N and check outputs after edges N..N+3.
    task automatic read_timing(input string tag, input logic [3:0] exp_flags,
                               input logic [23:0] da, input logic [23:0] db);
        @(negedge clk);
        idle();
        flags({tag, "@N"}, 4'b0000);
        @(negedge clk);
        flags({tag, "@N+1"}, 4'b0000);
        @(negedge clk);
        flags({tag, "@N+2"}, exp_flags);
        if (exp_flags[3]) chk({tag, ".data_a"}, 32'(rd_data_a), 32'(da));
        if (exp_flags[1]) chk({tag, ".data_b"}, 32'(rd_data_b), 32'(db));
        @(negedge clk);
        flags({tag, "@N+3"}, 4'b0000);
    endtask

    // Count edges until init_done, watching for any port response meanwhile.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (cycles < 30000) begin
            @(negedge clk);
            cycles++;
            if (rd_valid_a || rd_valid_b || err_a || err_b) spurious++;
            if (init_done) break;
        end
    endtask

    initial begin
        idle();
        spurious = 0;
        repeat (3) @(negedge clk);
        flags("reset_flags", 4'b0000);
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_rd_data", 32'({rd_data_a, rd_data_b} != 48'd0), 32'd0);

        // Release reset while both ports hammer the RAM; INIT must ignore them.
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 0, 24'hFFFFFF, 3'b111);
        set_b(1'b1, 1'b1, 0, 24'h0, 3'b000);
        wait_init(n);
        idle();
        chk("init_cycles", 32'(n), 32'(LINES + 1));
        chk("init_ignored", 32'(spurious), 32'd0);

        set_a(1'b1, 1'b1, 0, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, LINES - 1, 24'h0, 3'b000);
        read_timing("cleared", 4'b1010, 24'h000000, 24'h000000);

        set_a(1'b1, 1'b0, 5, 24'hABCDEF, 3'b111);
        issue();
        set_b(1'b1, 1'b1, 5, 24'h0, 3'b000);
        read_timing("wr_rd5", 4'b0010, 24'h0, 24'hABCDEF);

        set_a(1'b1, 1'b0, 7, 24'h111111, 3'b011);
        set_b(1'b1, 1'b0, 7, 24'h222222, 3'b110);
        issue();
        set_a(1'b1, 1'b1, 7, 24'h0, 3'b000);
        read_timing("dual_wr7", 4'b1000, 24'h221111, 24'h0);
        chk("hold_a", 32'(rd_data_a), 32'h221111);

        set_a(1'b1, 1'b0, 9, 24'h123456, 3'b111);
        issue();
        set_a(1'b1, 1'b0, 9, 24'h654321, 3'b111);
        set_b(1'b1, 1'b1, 9, 24'h0, 3'b000);
        read_timing("collide9", 4'b0010, 24'h0, ExpCollide);
        set_a(1'b1, 1'b1, 9, 24'h0, 3'b000);
        read_timing("after9", 4'b1000, 24'h654321, 24'h0);

        set_a(1'b1, 1'b0, 5, 24'h000000, 3'b010);
        issue();
        set_b(1'b1, 1'b0, 5, 24'hFFFFFF, 3'b000);
        issue();
        set_a(1'b1, 1'b1, 5, 24'h0, 3'b000);
        read_timing("be_partial", 4'b1000, 24'hAB00EF, 24'h0);

        set_a(1'b1, 1'b1, LINES, 24'h0, 3'b000);
        read_timing("oor_rd", 4'b1100, 24'h000000, 24'h0);
        set_a(1'b1, 1'b0, LINES, 24'hFFFFFF, 3'b111);
        read_timing("oor_wr", 4'b0100, 24'h0, 24'h0);
        set_a(1'b1, 1'b1, 0, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, LINES - 1, 24'h0, 3'b000);
        read_timing("oor_untouched", 4'b1010, 24'h000000, 24'h000000);

        // Back-to-back reads: A 5,7,9 and B 9,7,5.
        set_a(1'b1, 1'b1, 5, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, 9, 24'h0, 3'b000);
        @(negedge clk);
        flags("pipe@N", 4'b0000);
        set_a(1'b1, 1'b1, 7, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, 7, 24'h0, 3'b000);
        @(negedge clk);
        flags("pipe@N+1", 4'b0000);
        set_a(1'b1, 1'b1, 9, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, 5, 24'h0, 3'b000);
        @(negedge clk);
        idle();
        flags("pipe@N+2", 4'b1010);
        chk("pipe0.a", 32'(rd_data_a), 32'hAB00EF);
        chk("pipe0.b", 32'(rd_data_b), 32'h654321);
        @(negedge clk);
        flags("pipe@N+3", 4'b1010);
        chk("pipe1.a", 32'(rd_data_a), 32'h221111);
        chk("pipe1.b", 32'(rd_data_b), 32'h221111);
        @(negedge clk);
        flags("pipe@N+4", 4'b1010);
        chk("pipe2.a", 32'(rd_data_a), 32'h654321);
        chk("pipe2.b", 32'(rd_data_b), 32'hAB00EF);
        @(negedge clk);
        flags("pipe@N+5", 4'b0000);

        // Reset in READY with two reads in flight.
        set_a(1'b1, 1'b1, 5, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, 7, 24'h0, 3'b000);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        flags("flush_flags", 4'b0000);
        chk("flush_init_done", 32'(init_done), 32'd0);
        chk("flush_rd_data", 32'({rd_data_a, rd_data_b} != 48'd0), 32'd0);

        // Let clearing reach cnt=100, then reset again mid-INIT.
        spurious = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (rd_valid_a || rd_valid_b || err_a || err_b) spurious++;
        end
        chk("mid_init_low", 32'(init_done), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_cycles", 32'(n), 32'(LINES + 1));
        chk("flushed_no_valid", 32'(spurious), 32'd0);

        set_a(1'b1, 1'b1, 5, 24'h0, 3'b000);
        set_b(1'b1, 1'b1, 7, 24'h0, 3'b000);
        read_timing("recleared", 4'b1010, 24'h000000, 24'h000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
